// File: rtl/f_eval_arbiter.sv
// ----------------------------------------------------------------------------
// f_eval_arbiter
//
// Shares one combinational evaluation cone (output g217) between four
// requesters. A round-robin arbiter picks a requester. The sequencer then
// drives the cone's row/column bank selects and raises eval_en for SETTLE_CYC
// settle cycles plus one sample cycle. It captures the cone result and returns
// it to the requester through a valid/ready handshake.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   req         per-requester level request
//   req_row     2-bit row-bank select per requester, [2i+1:2i]
//   req_col     2-bit column-bank select per requester, [2i+1:2i]
//   gnt         one-hot grant, high for the whole transaction
//   row_sel     registered row-bank select to the cone
//   col_sel     registered column-bank select to the cone
//   eval_en     cone evaluation enable
//   f_result    cone output
//   resp_valid  response valid
//   resp_id     index of the requester being answered
//   resp_data   sampled cone result
//   resp_ready  response accepted
//
// Optional build macro FSEL_STATS_EN adds the eval_count and hit_count outputs.
// These are saturating counters of sample cycles and of sample cycles that
// returned 1.
// ----------------------------------------------------------------------------
module f_eval_arbiter #(
    parameter int NREQ       = 4,   // arbiter logic is written for exactly 4
    parameter int SETTLE_CYC = 2    // legal range 1..15
`ifdef FSEL_STATS_EN
    ,
    parameter int CNT_W      = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [2*NREQ-1:0] req_row,
    input  logic [2*NREQ-1:0] req_col,
    output logic [NREQ-1:0]   gnt,
    output logic [1:0]        row_sel,
    output logic [1:0]        col_sel,
    output logic              eval_en,
    input  logic              f_result,
    output logic              resp_valid,
    output logic [1:0]        resp_id,
    output logic              resp_data,
    input  logic              resp_ready
`ifdef FSEL_STATS_EN
    ,
    output logic [CNT_W-1:0]  eval_count,
    output logic [CNT_W-1:0]  hit_count
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SETTLE,
        SAMPLE,
        RESP
    } state_t;

    state_t     state;
    logic [1:0] last;        // most recently granted requester
    logic [3:0] settle_cnt;
    logic [1:0] winner;
    logic       found;
    logic [1:0] idx;

    // Round-robin search: the requester after the last winner has top priority.
    // The 2-bit index wraps modulo 4 by itself.
    // NOTE: every variable assigned in always_comb gets a default first.
    // Without the default, a path that leaves it unassigned infers a latch.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    // Sequencer. All outputs are registered and change only on the clock edge.
    // NOTE: sequential state uses non-blocking assignments (<=). All registers
    // therefore update together from values sampled before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last       <= 2'd3;
            settle_cnt <= '0;
            gnt        <= '0;
            row_sel    <= '0;
            col_sel    <= '0;
            eval_en    <= 1'b0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_data  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state   <= SETUP;
                        gnt     <= 4'b0001 << winner;
                        // Operand selects are captured here and nowhere else.
                        row_sel <= req_row[2*winner +: 2];
                        col_sel <= req_col[2*winner +: 2];
                        last    <= winner;
                    end
                end
                SETUP: begin
                    state      <= SETTLE;
                    eval_en    <= 1'b1;
                    settle_cnt <= 4'(SETTLE_CYC - 1);
                end
                SETTLE: begin
                    if (settle_cnt == '0) begin
                        state <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                SAMPLE: begin
                    state      <= RESP;
                    eval_en    <= 1'b0;
                    resp_data  <= f_result;
                    resp_valid <= 1'b1;
                    resp_id    <= last;
                end
                RESP: begin
                    // The response is held until it is accepted. A dropped
                    // req does not abort the transaction.
                    if (resp_ready) begin
                        state      <= IDLE;
                        gnt        <= '0;
                        resp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FSEL_STATS_EN
    // Saturating statistics counters. Each SAMPLE cycle counts as one
    // evaluation.
    always_ff @(posedge clk) begin
        if (rst) begin
            eval_count <= '0;
            hit_count  <= '0;
        end else if (state == SAMPLE) begin
            if (eval_count != '1) eval_count <= eval_count + 1'b1;
            if (f_result && (hit_count != '1)) hit_count <= hit_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_f_eval_arbiter.sv
// ----------------------------------------------------------------------------
// tb_f_eval_arbiter
//
// Self-checking bench for f_eval_arbiter. The reference model works at the
// transaction level. It records who is being served and how many cycles have
// passed since that grant. Every expected output comes from that position in
// the transaction: setup, settle window, sample, or response.
// ----------------------------------------------------------------------------
module tb_f_eval_arbiter;

    localparam int S     = 2;   // settle cycles
    localparam int CNT_W = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [7:0] req_row;
    logic [7:0] req_col;
    logic [3:0] gnt;
    logic [1:0] row_sel;
    logic [1:0] col_sel;
    logic       eval_en;
    logic       f_result;
    logic       resp_valid;
    logic [1:0] resp_id;
    logic       resp_data;
    logic       resp_ready;
`ifdef FSEL_STATS_EN
    logic [CNT_W-1:0] eval_count;
    logic [CNT_W-1:0] hit_count;
`endif

    always #5 clk = ~clk;

    f_eval_arbiter #(.SETTLE_CYC(S)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_row    (req_row),
        .req_col    (req_col),
        .gnt        (gnt),
        .row_sel    (row_sel),
        .col_sel    (col_sel),
        .eval_en    (eval_en),
        .f_result   (f_result),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .resp_ready (resp_ready)
`ifdef FSEL_STATS_EN
        ,
        .eval_count (eval_count),
        .hit_count  (hit_count)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Transaction-level reference model.
    // m_t counts cycles since the grant: 0 = setup, 1..S = settle,
    // S+1 = sample, S+2 = response pending.
    bit         m_busy;
    int         m_t;
    int         m_ptr;
    int         m_win;
    logic [1:0] m_row, m_col, m_rid;
    logic       m_rdata;
    int         m_evals, m_hits;

    task automatic model_step();
        if (rst) begin
            m_busy = 0; m_t = 0; m_ptr = 3; m_win = 0;
            m_row = 0; m_col = 0; m_rid = 0; m_rdata = 0;
            m_evals = 0; m_hits = 0;
        end else if (!m_busy) begin
            for (int k = 1; k <= 4; k++) begin
                int c;
                c = (m_ptr + k) % 4;
                if (!m_busy && req[c]) begin
                    m_busy = 1; m_t = 0; m_win = c; m_ptr = c;
                    m_row = req_row[2*c +: 2];
                    m_col = req_col[2*c +: 2];
                end
            end
        end else if (m_t == S + 1) begin
            m_rdata = f_result;
            m_rid   = 2'(m_win);
            if (m_evals < 65535) m_evals++;
            if (f_result && m_hits < 65535) m_hits++;
            m_t++;
        end else if (m_t < S + 1) begin
            m_t++;
        end else if (resp_ready) begin
            m_busy = 0;
        end
    endtask

    task automatic compare_all();
        logic exp_valid;
        exp_valid = m_busy && (m_t == S + 2);
        check("gnt", 32'(gnt), m_busy ? (32'd1 << m_win) : 32'd0);
        check("row_sel", 32'(row_sel), 32'(m_row));
        check("col_sel", 32'(col_sel), 32'(m_col));
        check("eval_en", 32'(eval_en), 32'(m_busy && m_t >= 1 && m_t <= S + 1));
        check("resp_valid", 32'(resp_valid), 32'(exp_valid));
        if (exp_valid) begin
            check("resp_id", 32'(resp_id), 32'(m_rid));
            check("resp_data", 32'(resp_data), 32'(m_rdata));
        end
`ifdef FSEL_STATS_EN
        check("eval_count", 32'(eval_count), 32'(m_evals));
        check("hit_count", 32'(hit_count), 32'(m_hits));
`endif
    endtask

    // One clock: the model consumes the inputs present at the edge, and the
    // outputs are compared 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    int eval_cnt, valid_cnt;
    int g_idx[8];
    int g_cyc[8];
    int n_g;
    logic [3:0] prev_gnt;

    initial begin
        rst = 1'b1; req = '0; req_row = '0; req_col = '0;
        f_result = 1'b0; resp_ready = 1'b0;
        repeat (2) cycle();
        check("reset_gnt", 32'(gnt), 32'd0);
        check("reset_eval_en", 32'(eval_en), 32'd0);
        check("reset_resp_id", 32'(resp_id), 32'd0);
        check("reset_resp_data", 32'(resp_data), 32'd0);

        // Single requester, ready always high.
        rst = 1'b0; req = 4'b0001; req_row = 8'h02; req_col = 8'h01;
        f_result = 1'b1; resp_ready = 1'b1;
        cycle();
        eval_cnt = 0; valid_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            eval_cnt  += int'(eval_en);
            valid_cnt += int'(resp_valid);
        end
        check("single_eval_cycles", 32'(eval_cnt), 32'(S + 1));
        check("single_valid_cycles", 32'(valid_cnt), 32'd1);
        req = '0;
        repeat (3) cycle();

        // All four requesting: round-robin order, one grant every S+4 cycles.
        rst = 1'b1; cycle(); rst = 1'b0;
        req = 4'b1111; req_row = 8'b11_10_01_00; req_col = 8'b00_01_10_11;
        n_g = 0; prev_gnt = '0;
        for (int c = 0; c < 32; c++) begin
            cycle();
            if (prev_gnt == 0 && gnt != 0 && n_g < 8) begin
                for (int b = 0; b < 4; b++) if (gnt[b]) g_idx[n_g] = b;
                g_cyc[n_g] = c;
                n_g++;
            end
            prev_gnt = gnt;
        end
        check("rr_grant_count", 32'(n_g >= 5), 32'd1);
        for (int i = 0; i < 5; i++) check("rr_order", 32'(g_idx[i]), 32'(i % 4));
        for (int i = 1; i < 5; i++) check("rr_spacing", 32'(g_cyc[i] - g_cyc[i-1]), 32'(S + 4));
        req = '0;

        // Response back-pressure: hold ready low through the response.
        rst = 1'b1; cycle(); rst = 1'b0;
        req = 4'b0110; resp_ready = 1'b0; f_result = 1'b0;
        for (int c = 0; c < S + 4 + 10; c++) cycle();
        check("bp_held_valid", 32'(resp_valid), 32'd1);
        check("bp_held_gnt", 32'(gnt), 32'b0010);
        resp_ready = 1'b1;
        repeat (3) cycle();
        check("bp_next_gnt", 32'(gnt), 32'b0100);
        req = '0;
        repeat (S + 5) cycle();

        // Change the granted operands during settle and drop req.
        req = 4'b1000; req_row = 8'hC0; f_result = 1'b1;
        repeat (3) cycle();
        req_row = 8'h00; req = '0;
        repeat (S + 4) cycle();

        // Reset mid-settle, then a contested request starts over at 0.
        req = 4'b0100;
        repeat (3) cycle();
        rst = 1'b1; cycle(); rst = 1'b0;
        check("rst_mid_gnt", 32'(gnt), 32'd0);
        req = 4'b1001;
        cycle();
        check("after_rst_gnt", 32'(gnt), 32'b0001);
        req = '0;
        repeat (S + 5) cycle();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            rst        = ($urandom_range(0, 199) == 0);
            req        = 4'($urandom);
            req_row    = 8'($urandom);
            req_col    = 8'($urandom);
            f_result   = 1'($urandom);
            resp_ready = ($urandom_range(0, 9) < 7);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
